// File: rtl/sponge_feeder_pkg.sv
// rtl/sponge_feeder_pkg.sv - shared constants, mode encoding and state enum for the sponge feeder
package sponge_feeder_pkg;

  localparam int BLOCK_BYTES = 128;
  localparam int BLOCK_BITS  = 1024;
  localparam int DIGEST_BITS = 512;

  localparam logic MODE_SHAKE128 = 1'b0;
  localparam logic MODE_SHAKE256 = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_SEND,
    ST_WAIT_DONE,
    ST_DRAIN
  } feeder_state_e;

endpackage

// File: rtl/sponge_feeder_if.sv
// rtl/sponge_feeder_if.sv - byte input, core block/digest handshake and digest word output bundle
interface sponge_feeder_if;
  import sponge_feeder_pkg::*;

  logic [7:0]             s_data;
  logic                   s_valid;
  logic                   s_last;
  logic                   s_ready;
  logic                   cfg_mode;
  logic [BLOCK_BITS-1:0]  h_din;
  logic [6:0]             h_byte_len;
  logic                   h_valid;
  logic                   h_last;
  logic                   h_mode;
  logic                   h_ack;
  logic [DIGEST_BITS-1:0] h_dout;
  logic                   h_done;
  logic [63:0]            m_data;
  logic                   m_valid;
  logic                   m_last;
  logic                   m_ready;
  logic                   busy;

  modport master (
    input  s_data, s_valid, s_last, cfg_mode, h_ack, h_dout, h_done, m_ready,
    output s_ready, h_din, h_byte_len, h_valid, h_last, h_mode, m_data, m_valid, m_last, busy
  );

  modport slave (
    output s_data, s_valid, s_last, cfg_mode, h_ack, h_dout, h_done, m_ready,
    input  s_ready, h_din, h_byte_len, h_valid, h_last, h_mode, m_data, m_valid, m_last, busy
  );

endinterface

// File: rtl/sponge_feeder_digest_serializer.sv
// rtl/sponge_feeder_digest_serializer.sv - holds the 512-bit digest and unloads it as 64-bit words
module digest_serializer
  import sponge_feeder_pkg::*;
#(
  parameter int WORDS = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   load,
  input  logic [DIGEST_BITS-1:0] din,
  input  logic                   m_ready,
  output logic [63:0]            m_data,
  output logic                   m_valid,
  output logic                   m_last,
  output logic                   drained
);

  localparam logic [2:0] LAST_IDX = 3'(WORDS - 1);

  logic [DIGEST_BITS-1:0] digest_q, digest_d;
  logic [2:0]             idx_q, idx_d;
  logic                   valid_q, valid_d;
  logic                   at_last;

  always_comb begin
    digest_d = digest_q;
    idx_d    = idx_q;
    valid_d  = valid_q;
    at_last  = (idx_q == LAST_IDX);
    drained  = valid_q && m_ready && at_last;
    if (load) begin
      digest_d = din;
      idx_d    = 3'd0;
      valid_d  = 1'b1;
    end else if (valid_q && m_ready) begin
      if (at_last) begin
        valid_d = 1'b0;
        idx_d   = 3'd0;
      end else begin
        idx_d = idx_q + 3'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digest_q <= '0;
      idx_q    <= 3'd0;
      valid_q  <= 1'b0;
    end else begin
      digest_q <= digest_d;
      idx_q    <= idx_d;
      valid_q  <= valid_d;
    end
  end

  assign m_data  = digest_q[{idx_q, 6'b000000} +: 64];
  assign m_valid = valid_q;
  assign m_last  = valid_q && at_last;

endmodule

// File: rtl/sponge_feeder.sv
// rtl/sponge_feeder.sv - packs a byte stream into 1024-bit sponge blocks and streams the digest back out
module sponge_feeder
  import sponge_feeder_pkg::*;
#(
  parameter int DIGEST_WORDS = 8
) (
  input logic             clk,
  input logic             rst_n,
  sponge_feeder_if.master bus
);

  feeder_state_e         state_q, state_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [BLOCK_BITS-1:0] buf_q, buf_d;
  logic [6:0]            byte_len_q, byte_len_d;
  logic                  last_q, last_d;
  logic                  mode_q, mode_d;
  logic                  pend_empty_q, pend_empty_d;
  logic                  s_ready_q, s_ready_d;
  logic                  accept;
  logic [7:0]            new_cnt;
  logic                  digest_load;
  logic                  drain_done;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    buf_d        = buf_q;
    byte_len_d   = byte_len_q;
    last_d       = last_q;
    mode_d       = mode_q;
    pend_empty_d = pend_empty_q;
    digest_load  = 1'b0;
    accept       = bus.s_valid && s_ready_q;
    new_cnt      = cnt_q + 8'd1;

    case (state_q)
      ST_IDLE, ST_FILL: begin
        if (accept) begin
          if (state_q == ST_IDLE) mode_d = bus.cfg_mode;
          buf_d[{cnt_q[6:0], 3'b000} +: 8] = bus.s_data;
          cnt_d   = new_cnt;
          state_d = ST_FILL;
          // A message ending exactly on a block boundary still needs an empty final block.
          if (new_cnt == 8'(BLOCK_BYTES)) begin
            state_d      = ST_SEND;
            last_d       = 1'b0;
            byte_len_d   = 7'd0;
            pend_empty_d = bus.s_last;
          end else if (bus.s_last) begin
            state_d    = ST_SEND;
            last_d     = 1'b1;
            byte_len_d = new_cnt[6:0];
          end
        end
      end
      ST_SEND: begin
        if (bus.h_ack) begin
          buf_d      = '0;
          cnt_d      = 8'd0;
          byte_len_d = 7'd0;
          last_d     = 1'b0;
          if (last_q) begin
            state_d = ST_WAIT_DONE;
          end else if (pend_empty_q) begin
            last_d       = 1'b1;
            pend_empty_d = 1'b0;
          end else begin
            state_d = ST_FILL;
          end
        end
      end
      ST_WAIT_DONE: begin
        if (bus.h_done) begin
          digest_load = 1'b1;
          state_d     = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (drain_done) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    s_ready_d = (state_d == ST_IDLE) || (state_d == ST_FILL);
  end

  // s_ready is registered so it stays low while reset is held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 8'd0;
      buf_q        <= '0;
      byte_len_q   <= 7'd0;
      last_q       <= 1'b0;
      mode_q       <= MODE_SHAKE128;
      pend_empty_q <= 1'b0;
      s_ready_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      buf_q        <= buf_d;
      byte_len_q   <= byte_len_d;
      last_q       <= last_d;
      mode_q       <= mode_d;
      pend_empty_q <= pend_empty_d;
      s_ready_q    <= s_ready_d;
    end
  end

  assign bus.s_ready    = s_ready_q;
  assign bus.h_din      = buf_q;
  assign bus.h_byte_len = byte_len_q;
  assign bus.h_valid    = (state_q == ST_SEND);
  assign bus.h_last     = last_q;
  assign bus.h_mode     = mode_q;
  assign bus.busy       = (state_q != ST_IDLE);

  digest_serializer #(
    .WORDS (DIGEST_WORDS)
  ) u_digest_serializer (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (digest_load),
    .din     (bus.h_dout),
    .m_ready (bus.m_ready),
    .m_data  (bus.m_data),
    .m_valid (bus.m_valid),
    .m_last  (bus.m_last),
    .drained (drain_done)
  );

endmodule

// File: tb/tb_sponge_feeder.sv
// tb/tb_sponge_feeder.sv - randomized bench for sponge_feeder against a block/digest reference model
`timescale 1ns/1ps
module tb_sponge_feeder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [7:0]   s_data = '0;
  logic         s_valid = 1'b0;
  logic         s_last = 1'b0;
  logic         cfg_mode = 1'b0;
  logic         h_ack = 1'b0;
  logic         h_done = 1'b0;
  logic [511:0] h_dout = '0;
  logic         mr_a = 1'b0;
  logic         mr_b = 1'b0;

  sponge_feeder_if ifa();
  sponge_feeder_if ifb();

  assign ifa.s_data = s_data;   assign ifb.s_data = s_data;
  assign ifa.s_valid = s_valid; assign ifb.s_valid = s_valid;
  assign ifa.s_last = s_last;   assign ifb.s_last = s_last;
  assign ifa.cfg_mode = cfg_mode; assign ifb.cfg_mode = cfg_mode;
  assign ifa.h_ack = h_ack;     assign ifb.h_ack = h_ack;
  assign ifa.h_dout = h_dout;   assign ifb.h_dout = h_dout;
  assign ifa.h_done = h_done;   assign ifb.h_done = h_done;
  assign ifa.m_ready = mr_a;    assign ifb.m_ready = mr_b;

  sponge_feeder #(.DIGEST_WORDS(8)) u_dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
  sponge_feeder #(.DIGEST_WORDS(4)) u_dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0]    msg[$];
  logic [1023:0] exp_din[$];
  logic [6:0]    exp_blen[$];
  logic          exp_last[$];
  logic [511:0]  exp_digest = '0;
  logic          exp_mode = 1'b0;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Split the message into 128-byte blocks; the final block carries the remainder (possibly none).
  task automatic build_model(input int len);
    int full;
    int rem;
    logic [1023:0] d;
    full = len / 128;
    rem  = len % 128;
    exp_din.delete(); exp_blen.delete(); exp_last.delete();
    for (int b = 0; b < full; b++) begin
      d = '0;
      for (int k = 0; k < 128; k++) d[8*k +: 8] = msg[128*b + k];
      exp_din.push_back(d); exp_blen.push_back(7'd0); exp_last.push_back(1'b0);
    end
    d = '0;
    for (int k = 0; k < rem; k++) d[8*k +: 8] = msg[128*full + k];
    exp_din.push_back(d); exp_blen.push_back(7'(rem)); exp_last.push_back(1'b1);
  endtask

  task automatic check_reset_vals();
    check("rst_s_ready", ifa.s_ready, 0);
    check("rst_h_valid", ifa.h_valid, 0);
    check("rst_h_last", ifa.h_last, 0);
    check("rst_m_valid", ifa.m_valid, 0);
    check("rst_m_last", ifa.m_last, 0);
    check("rst_busy", ifa.busy, 0);
    check("rst_h_din", |ifa.h_din, 0);
    check("rst_h_byte_len", ifa.h_byte_len, 0);
    check("rst_h_mode", ifa.h_mode, 0);
    check("rst_m_data", ifa.m_data, 0);
    check("rst_b_m_valid", ifb.m_valid, 0);
    check("rst_b_busy", ifb.busy, 0);
  endtask

  task automatic drive_msg(input int len, input logic mode);
    int i;
    int guard;
    bit acc;
    i = 0;
    guard = 0;
    while (i < len && guard < 5000) begin
      if ($urandom_range(0, 7) == 0) begin
        s_valid = 1'b0;
        @(posedge clk); #1;
        guard++;
      end
      s_valid  = 1'b1;
      s_data   = msg[i];
      s_last   = (i == len - 1);
      cfg_mode = (i == 0) ? mode : 1'($urandom_range(0, 1));
      acc = ifa.s_ready;
      @(posedge clk); #1;
      guard++;
      if (acc) begin
        if ((i % 128 == 127) || (i == len - 1)) check("h_valid_rise", ifa.h_valid, 1);
        i++;
      end
    end
    if (i < len) check("drive_timeout", 0, 1);
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic core(input int ack_delay, input logic [511:0] dig, input bit stop_in_send);
    int nb;
    logic [1023:0] d;
    bit stay;
    nb = exp_din.size();
    for (int b = 0; b < nb; b++) begin
      int g = 0;
      while (!ifa.h_valid && g < 5000) begin
        @(posedge clk); #1;
        g++;
      end
      check("h_valid_wait", ifa.h_valid, 1);
      d = exp_din[b];
      for (int s = 0; s < 4; s++)
        check($sformatf("blk%0d_din%0d", b, s), ifa.h_din[256*s +: 256], d[256*s +: 256]);
      check($sformatf("blk%0d_byte_len", b), ifa.h_byte_len, exp_blen[b]);
      check($sformatf("blk%0d_last", b), ifa.h_last, exp_last[b]);
      check($sformatf("blk%0d_mode", b), ifa.h_mode, exp_mode);
      check("s_ready_in_send", ifa.s_ready, 0);
      if (stop_in_send) return;
      for (int w = 0; w < ack_delay; w++) begin
        @(posedge clk); #1;
        check("hold_h_valid", ifa.h_valid, 1);
        check("hold_h_din", ifa.h_din === d, 1);
        check("hold_byte_len", ifa.h_byte_len, exp_blen[b]);
        check("hold_h_last", ifa.h_last, exp_last[b]);
        check("hold_s_ready", ifa.s_ready, 0);
      end
      h_ack = 1'b1;
      @(posedge clk); #1;
      h_ack = 1'b0;
      stay = (b + 1 < nb) && exp_last[b + 1] && (exp_blen[b + 1] == 7'd0);
      check("h_valid_after_ack", ifa.h_valid, stay);
    end
    for (int w = 0; w < $urandom_range(0, 3); w++) begin
      check("wait_done_busy", ifa.busy, 1);
      check("wait_done_m_valid", ifa.m_valid, 0);
      @(posedge clk); #1;
    end
    exp_digest = dig;
    h_dout = dig;
    h_done = 1'b1;
    @(posedge clk); #1;
    h_done = 1'b0;
    check("m_valid_rise_a", ifa.m_valid, 1);
    check("m_valid_rise_b", ifb.m_valid, 1);
  endtask

  task automatic sink(input bit sel, input int dw, input int pat, input bit early);
    int k;
    int cyc;
    logic mr;
    logic mv;
    k = 0;
    cyc = 0;
    while (k < dw && cyc < 6000) begin
      case (pat)
        0:       mr = 1'b1;
        1:       mr = (cyc % 3 == 0);
        default: mr = 1'($urandom_range(0, 1));
      endcase
      if (sel) mr_b = mr; else mr_a = mr;
      mv = sel ? ifb.m_valid : ifa.m_valid;
      if (mv) begin
        check(sel ? "m_data_b" : "m_data_a", sel ? ifb.m_data : ifa.m_data, exp_digest[64*k +: 64]);
        check(sel ? "m_last_b" : "m_last_a", sel ? ifb.m_last : ifa.m_last, k == dw - 1);
        if (early) begin
          if (sel) mr_b = 1'b0; else mr_a = 1'b0;
          return;
        end
        if (mr) k++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    if (sel) mr_b = 1'b0; else mr_a = 1'b0;
    check(sel ? "word_count_b" : "word_count_a", k, dw);
    check(sel ? "m_valid_end_b" : "m_valid_end_a", sel ? ifb.m_valid : ifa.m_valid, 0);
    check(sel ? "busy_end_b" : "busy_end_a", sel ? ifb.busy : ifa.busy, 0);
  endtask

  // stop: 0 full run, 1 abandon in SEND, 2 abandon in DRAIN
  task automatic run_msg(input logic mode, input int ack_delay, input int pat,
                         input bit ramp_digest, input int stop);
    logic [511:0] dig;
    int len;
    len = msg.size();
    for (int i = 0; i < 8; i++)
      dig[64*i +: 64] = ramp_digest ? 64'(i) : {$urandom, $urandom};
    exp_mode = mode;
    build_model(len);
    fork
      drive_msg(len, mode);
      core(ack_delay, dig, stop == 1);
      if (stop != 1) sink(1'b0, 8, pat, stop == 2);
      if (stop != 1) sink(1'b1, 4, pat, stop == 2);
    join
  endtask

  task automatic random_msg(input int len);
    msg.delete();
    for (int i = 0; i < len; i++) msg.push_back(8'($urandom));
  endtask

  task automatic reset_pulse();
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_vals();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("s_ready_after_reset", ifa.s_ready, 1);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals();
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("s_ready_after_reset", ifa.s_ready, 1);

    msg.delete();
    msg.push_back(8'h61); msg.push_back(8'h62); msg.push_back(8'h63);
    run_msg(1'b1, 0, 0, 1'b1, 0);

    random_msg(128);
    run_msg(1'b0, 1, 2, 1'b0, 0);

    random_msg(130);
    run_msg(1'b1, 5, 1, 1'b0, 0);

    random_msg(256);
    run_msg(1'b1, 2, 2, 1'b0, 0);

    for (int t = 0; t < 5; t++) begin
      random_msg($urandom_range(1, 300));
      run_msg(1'($urandom_range(0, 1)), $urandom_range(0, 5), $urandom_range(0, 2), 1'b0, 0);
    end

    random_msg(5);
    run_msg(1'b1, 0, 0, 1'b0, 1);
    reset_pulse();
    msg.delete();
    msg.push_back(8'hAA);
    run_msg(1'b0, 0, 0, 1'b0, 0);

    random_msg(20);
    run_msg(1'b1, 1, 0, 1'b0, 2);
    reset_pulse();
    msg.delete();
    msg.push_back(8'hAA);
    run_msg(1'b1, 3, 1, 1'b1, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", n_errors, n_checks);
    $fatal(1);
  end

endmodule

// File: doc/sponge_feeder.md
# sponge_feeder

Message-side front end for the Keccak sponge core. It accepts a message as a byte stream with valid/ready handshaking and packs it little-endian into 1024-bit blocks. It drives the core's block handshake (`din`/`byte_len`/`i_valid`/`i_last`/`mode`/`i_ack`), including the final-block length. It then captures the 512-bit digest on `done` and streams it out as 64-bit words.

## Interface
- `DIGEST_WORDS`, default 8: number of 64-bit digest words emitted, legal 1..8; words are taken from digest bit 0 upward.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `s_data` in 8: message byte.
- `s_valid` in 1: byte valid.
- `s_last` in 1: final byte of message, qualified by `s_valid`.
- `s_ready` out 1: feeder can take a byte.
- `cfg_mode` in 1: 0 SHAKE128, 1 SHAKE256; latched on the first accepted byte of a message.
- `h_din` out 1024: block data; byte k sits at bits [8k+7:8k]; unused bytes are zero.
- `h_byte_len` out 7: valid bytes in the final block, 0..127; 0 on non-final blocks.
- `h_valid` out 1: block offered to the core.
- `h_last` out 1: offered block is the final block.
- `h_mode` out 1: latched mode.
- `h_ack` in 1: one-cycle accept pulse from the core.
- `h_dout` in 512: digest from the core.
- `h_done` in 1: digest valid, level.
- `m_data` out 64: digest word.
- `m_valid` out 1: digest word valid.
- `m_last` out 1: last digest word.
- `m_ready` in 1: sink accepts the word.
- `busy` out 1: high in any state except IDLE.

## Operation
- States: IDLE, FILL, SEND, WAIT_DONE, DRAIN.
- **IDLE**
  - `s_ready`=1.
  - A byte is accepted when `s_valid`&`s_ready`. The first accepted byte latches `cfg_mode` into `h_mode`, is written to byte 0, sets cnt=1 and moves to FILL.
  - If that byte also has `s_last`, the block is closed immediately (see FILL close rules).
- **FILL**
  - `s_ready`=1. Each accepted byte is written at index cnt and cnt increments. cnt is 8 bits, range 0..128.
  - Close rules on the accepting edge:
    - `s_last` with new cnt ≤127: final block, `h_byte_len`=cnt, go to SEND with `h_last`=1.
    - New cnt=128 without `s_last`: full non-final block, go to SEND with `h_last`=0.
    - New cnt=128 with `s_last`: full non-final block, set `pend_empty`, go to SEND with `h_last`=0.
- **SEND**
  - `s_ready`=0, `h_valid`=1. `h_din`, `h_byte_len`, `h_last` and `h_mode` are held stable until `h_ack`=1 is sampled.
  - On ack, the buffer is cleared to zero and cnt resets to 0.
  - Next state after ack:
    - `h_last`=1: WAIT_DONE.
    - `pend_empty`: stay in SEND with an empty final block (`h_byte_len`=0, `h_last`=1) and clear `pend_empty`.
    - Otherwise: FILL.
- **WAIT_DONE**
  - On `h_done`=1, copy `h_dout` into the digest register, set idx=0, go to DRAIN.
  - The core clears `done` on the same edge it pulses `i_ack`, so a stale `h_done` cannot be seen here.
- **DRAIN**
  - `m_valid`=1, `m_data`=digest[64·idx +: 64], `m_last`=(idx==DIGEST_WORDS-1).
  - idx advances on `m_valid`&`m_ready`. After the last word is accepted, go to IDLE.
- Mode is held constant for the whole message; `cfg_mode` changes mid-message are ignored.
- Reset mid-operation:
  - State returns to IDLE; buffer, digest, cnt, idx and `pend_empty` are cleared.
  - Any in-flight block or digest is discarded.
  - The core must be reset with the same `rst`/`rst_n` event.

## Timing
- Reset values:
  - `s_ready`=0 during reset, 1 after it releases into IDLE.
  - `h_valid`, `h_last`, `m_valid`, `m_last`, `busy` = 0.
  - `h_din`, `h_byte_len`, `h_mode`, `m_data` = 0.
- All outputs are registered or decoded from state; there are no combinational paths from inputs to outputs.
- Throughput and latency:
  - Byte input: 1 byte/cycle, with no bubbles inside a block.
  - `h_valid` rises on the cycle after the closing byte is accepted.
  - `h_valid` drops on the cycle after `h_ack`.
  - `m_valid` rises on the cycle after `h_done` is sampled.
  - Digest output: 1 word/cycle when `m_ready`=1.
- A zero-length message is impossible: the first accepted byte always counts.

## Structure
- Shared package holds:
  - Constants BLOCK_BYTES=128, BLOCK_BITS=1024, DIGEST_BITS=512.
  - Mode encoding MODE_SHAKE128=0, MODE_SHAKE256=1.
  - The feeder state enum.
- One natural sub-module: `digest_serializer` (512-bit load, 64-bit valid/ready unload, `m_last` generation). Byte packing stays in the top level.

## Test plan
- "abc" (0x61,0x62,0x63, `s_last` on 0x63), `cfg_mode`=1 -> one block with `h_din`[23:0]=0x636261, rest zero, `h_byte_len`=3, `h_last`=1, `h_mode`=1. Drive `h_dout`=i·2^(64i) pattern and `h_done` -> 8 words 0..7 in order, `m_last` on word 7.
- 128-byte message -> block 1 full, `h_last`=0, `h_byte_len`=0; then an empty block, `h_last`=1, `h_byte_len`=0, `h_din`=0.
- 130-byte message -> block 1 full non-final; block 2 with `h_byte_len`=2 and bytes 128,129 at `h_din`[15:0].
- `h_ack` delayed 5 cycles -> `h_din`/`h_byte_len`/`h_last` stable throughout and `s_ready`=0; no byte is lost after ack.
- `m_ready` toggling 1,0,0,1… with `DIGEST_WORDS`=4 -> each word held until accepted, exactly 4 words, `m_last` on word 3, then IDLE.
- `rst_n` asserted in SEND and again in DRAIN -> next cycle all outputs at reset values. A following 1-byte message 0xAA gives `h_din`[7:0]=0xAA with the rest of `h_din` zero, and `h_byte_len`=1.
